// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one memory port between instruction fetch
// (read-only) and data access (read/write). Data has priority, bounded by a burst
// guard so fetch cannot starve. Fetch responses made stale by a flush are dropped.
module mem_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        flush_i,
  input  logic        IF_read_i,
  input  logic [31:0] IF_addr_i,
  output logic [31:0] IF_data_o,
  output logic        IF_valid_o,
  input  logic        DM_read_i,
  input  logic        DM_write_i,
  input  logic [31:0] DM_addr_i,
  input  logic [31:0] DM_wdata_i,
  input  logic [3:0]  DM_be_i,
  output logic [31:0] DM_data_o,
  output logic        DM_valid_o,
  output logic        MEM_req_o,
  output logic        MEM_we_o,
  output logic [31:0] MEM_addr_o,
  output logic [31:0] MEM_wdata_o,
  output logic [3:0]  MEM_be_o,
  input  logic [31:0] MEM_data_i,
  input  logic        MEM_valid_i
);

  typedef enum logic [1:0] {StIdle, StIfBusy, StDmBusy} state_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_DATA_BURST);

  state_e     state_q;
  logic [3:0] burst_q;
  logic       drop_q;
  logic       dm_req;
  logic       if_wins;

  assign dm_req  = DM_read_i | DM_write_i;
  // Fetch wins when data is idle, or when data has used up its burst allowance.
  assign if_wins = IF_read_i & (~dm_req | (burst_q == MaxBurst));

  // Read data is a straight pass-through; the valid pulses qualify it.
  assign IF_data_o = MEM_data_i;
  assign DM_data_o = MEM_data_i;

  // Response pulses coincide with the memory completion; a flush in the
  // completion cycle also kills the fetch response.
  assign IF_valid_o = (state_q == StIfBusy) & MEM_valid_i & ~drop_q & ~flush_i;
  assign DM_valid_o = (state_q == StDmBusy) & MEM_valid_i;

  // Arbitration FSM with registered memory-side outputs.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      burst_q     <= 4'd0;
      drop_q      <= 1'b0;
      MEM_req_o   <= 1'b0;
      MEM_we_o    <= 1'b0;
      MEM_addr_o  <= 32'd0;
      MEM_wdata_o <= 32'd0;
      MEM_be_o    <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (if_wins) begin
            state_q     <= StIfBusy;
            MEM_req_o   <= 1'b1;
            MEM_we_o    <= 1'b0;
            MEM_addr_o  <= IF_addr_i;
            MEM_wdata_o <= 32'd0;
            MEM_be_o    <= 4'hF;
            burst_q     <= 4'd0;
            drop_q      <= flush_i;
          end else if (dm_req) begin
            state_q     <= StDmBusy;
            MEM_req_o   <= 1'b1;
            MEM_we_o    <= DM_write_i;
            MEM_addr_o  <= DM_addr_i;
            MEM_wdata_o <= DM_wdata_i;
            MEM_be_o    <= DM_write_i ? DM_be_i : 4'hF;
            // Only data grants made while a fetch waits count toward the burst.
            if (!IF_read_i) begin
              burst_q <= 4'd0;
            end else if (burst_q != MaxBurst) begin
              burst_q <= burst_q + 4'd1;
            end
          end
        end
        StIfBusy: begin
          if (MEM_valid_i) begin
            state_q   <= StIdle;
            MEM_req_o <= 1'b0;
            drop_q    <= 1'b0;
          end else if (flush_i) begin
            drop_q <= 1'b1;
          end
        end
        StDmBusy: begin
          if (MEM_valid_i) begin
            state_q   <= StIdle;
            MEM_req_o <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sitting between the core pipeline and the unified instruction/data memory. It shares one request/response memory port between the instruction-fetch stage (read-only) and the memory-access stage (read/write). Data accesses have priority, with a bounded-burst guard that prevents fetch starvation. Fetch responses that a pipeline flush has made stale are dropped.

## Interface
Parameters:
- MAX_DATA_BURST, 4: max consecutive data grants while a fetch is pending; range 1..15.

Ports:
- clk  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  pipeline flush; marks any in-flight fetch as stale
- IF_read_i  in  1  fetch request, held until IF_valid_o or flush
- IF_addr_i  in  32  fetch address
- IF_data_o  out  32  fetch read data, valid with IF_valid_o
- IF_valid_o  out  1  one-cycle fetch response pulse
- DM_read_i  in  1  data read request, held until DM_valid_o
- DM_write_i  in  1  data write request, held until DM_valid_o; never asserted together with DM_read_i
- DM_addr_i  in  32  data address
- DM_wdata_i  in  32  write data
- DM_be_i  in  4  write byte enables
- DM_data_o  out  32  data read data, valid with DM_valid_o
- DM_valid_o  out  1  one-cycle data response pulse (reads and writes)
- MEM_req_o  out  1  memory request, held until MEM_valid_i
- MEM_we_o  out  1  write enable, qualified by MEM_req_o
- MEM_addr_o  out  32  registered address
- MEM_wdata_o  out  32  registered write data
- MEM_be_o  out  4  registered byte enables; 4'hF for reads
- MEM_data_i  in  32  memory read data
- MEM_valid_i  in  1  one-cycle memory completion pulse

## Operation
- FSM states: IDLE, IF_BUSY, DM_BUSY.
- IDLE: if any request is present, latch the winner's addr/wdata/be/we into the MEM_* registers and move to the matching BUSY state. MEM_req_o is a registered output and rises on the next cycle.
- Priority: data wins unless IF_read_i is set and burst_cnt == MAX_DATA_BURST. In that case fetch wins.
- burst_cnt (4 bit): increments on each data grant made while IF_read_i is high, saturating at MAX_DATA_BURST. Cleared on any fetch grant, and on any data grant with IF_read_i low.
- IF_BUSY / DM_BUSY: hold MEM_req_o and all MEM_* registers stable. On MEM_valid_i: deassert MEM_req_o, pulse the owner's valid for that same cycle, and return to IDLE.
- No new grant is made in the completion cycle. Minimum spacing between memory requests is therefore 1 idle cycle.
- IF_data_o and DM_data_o are combinational pass-throughs of MEM_data_i.
- Stale fetch: a drop flag is set when flush_i is asserted during IF_BUSY, or during IDLE in the cycle a fetch is granted. While drop is set, MEM_valid_i completes the transaction with IF_valid_o held at 0. The flag is cleared on that completion.
- flush_i has no effect on DM transactions.
- IF_read_i deasserting during IF_BUSY does not abort the transaction; the memory cycle completes.
- MEM_valid_i while in IDLE is ignored.

## Timing
- Reset values: MEM_req_o=0, MEM_we_o=0, MEM_addr_o=0, MEM_wdata_o=0, MEM_be_o=0, IF_valid_o=0, DM_valid_o=0, state=IDLE, burst_cnt=0, drop=0.
- Reset mid-transaction returns to IDLE immediately and drops MEM_req_o. The memory is reset by the same rstn_i.
- Latency: request seen at cycle 0 → MEM_req_o=1 at cycle 1 → response in the cycle MEM_valid_i arrives (≥ cycle 2 with a 1-cycle memory).
- Valid pulses are exactly 1 cycle wide and coincide with MEM_valid_i.
- Simultaneous IF and DM requests in IDLE: exactly one grant per IDLE cycle. The loser keeps its request asserted.
- flush_i in the same cycle as MEM_valid_i during IF_BUSY: the response is dropped, with IF_valid_o=0.

## Test plan
- Single fetch, addr 0x100, memory returns 0x00000013 one cycle after req → MEM_req_o=1 at cycle 1 with MEM_addr_o=0x100; IF_valid_o=1 with IF_data_o=0x13 at cycle 2.
- Data write, addr 0x2000, wdata 0xDEADBEEF, be 4'b0011 → MEM_we_o=1, MEM_be_o=4'b0011, MEM_wdata_o=0xDEADBEEF held until MEM_valid_i; DM_valid_o pulses 1 cycle; IF_valid_o stays 0.
- IF and DM requests both held continuously, MAX_DATA_BURST=4 → grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
- Flush during IF_BUSY, with memory valid arriving 3 cycles later → IF_valid_o stays 0. The next fetch request (new addr 0x400) is granted after IDLE and completes with IF_valid_o=1.
- Memory latency 5 cycles with DM_addr_i changed mid-transaction → MEM_addr_o keeps the originally latched value throughout.
- rstn_i asserted during DM_BUSY → all outputs return to reset values asynchronously. After release, a pending IF request is granted from IDLE.
